diff_order_scheduler: RTL and testbench

Shares one diff_order_calculator between NUM_CH requesters, each presenting a 12-bit L_mV sample. Round-robin arbitration; the granted sample is held on the calculator input long enough to guarantee a full computation frame regardless of the calculator's free-running phase. The resulting N is returned with channel tag, valid pulse and per-channel ack. Sits between the ADC sampling logic and the calculator instance.

---
 rtl/diff_order_pkg.sv | 26 ++
 rtl/diff_order_scheduler_if.sv | 31 +++
 rtl/diff_order_scheduler_rr_arbiter.sv | 41 ++++
 rtl/diff_order_scheduler.sv | 154 +++++++++++++++
 tb/tb_diff_order_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/diff_order_pkg.sv
// Shared widths, constants and state encoding for the diff-order scheduler.
package diff_order_pkg;

   localparam int unsigned L_W      = 12;
   localparam int unsigned N_W      = 16;
   localparam int unsigned CH_W     = 3;
   localparam int unsigned HOLD_MIN = 42;
   localparam logic [N_W-1:0] N_ERR = 16'hFFFF;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StHold    = 2'd1,
      StCapture = 2'd2,
      StErr     = 2'd3
   } state_e;

   // Next round-robin pointer after serving channel ch; wraps at num_ch-1 -> 0.
   function automatic logic [CH_W-1:0] ch_wrap_inc(input logic [CH_W-1:0] ch,
                                                   input int unsigned     num_ch);
      if (32'(ch) >= num_ch - 1) begin
         return '0;
      end
      return ch + 1'b1;
   endfunction

endpackage

// File: rtl/diff_order_scheduler_if.sv
// Request/result/calculator bundle between ADC sampling logic, scheduler and calculator.
interface diff_order_scheduler_if #(
   parameter int unsigned NUM_CH = 4
) ();
   import diff_order_pkg::*;

   logic [NUM_CH-1:0]     req;
   logic [L_W*NUM_CH-1:0] l_mv_flat;
   logic [NUM_CH-1:0]     ack;
   logic                  busy;
   logic                  res_valid;
   logic [CH_W-1:0]       res_ch;
   logic [N_W-1:0]        res_n;
   logic                  res_err;
   logic                  calc_en;
   logic [L_W-1:0]        calc_l_mv;
   logic [N_W-1:0]        calc_n;

   // Scheduler side.
   modport master (
      input  req, l_mv_flat, calc_n,
      output ack, busy, res_valid, res_ch, res_n, res_err, calc_en, calc_l_mv
   );

   // Requesters plus calculator side.
   modport slave (
      output req, l_mv_flat, calc_n,
      input  ack, busy, res_valid, res_ch, res_n, res_err, calc_en, calc_l_mv
   );

endinterface

// File: rtl/diff_order_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr_i, wrapping.
module rr_arbiter
   import diff_order_pkg::*;
#(
   parameter int unsigned NUM_CH = 4
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [CH_W-1:0]   ptr_i,
   output logic [NUM_CH-1:0] grant_o,
   output logic [CH_W-1:0]   idx_o,
   output logic              any_o
);

   localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   // Scan channels starting at the pointer; the first hit wins.
   always_comb begin
      int unsigned      c;
      logic [IdxW-1:0]  cidx;
      logic             found;
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      c       = 0;
      cidx    = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         c = 32'(ptr_i) + i;
         if (c >= NUM_CH) begin
            c = c - NUM_CH;
         end
         cidx = IdxW'(c);
         if (!found && req_i[cidx]) begin
            found         = 1'b1;
            grant_o[cidx] = 1'b1;
            idx_o         = CH_W'(c);
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/diff_order_scheduler.sv
// Time-shares one diff_order_calculator between NUM_CH requesters. A granted sample is held
// on the calculator input for HOLD_CYCLES so at least one full calculator frame completes
// whatever its free-running phase; the result is returned with channel tag, strobe and ack.
module diff_order_scheduler
   import diff_order_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned HOLD_CYCLES = 42
) (
   input  logic                          clk_50,
   input  logic                          areset,
   diff_order_scheduler_if.master        bus_io
);

   localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);

   state_e                state_q, state_d;
   logic [CntW-1:0]       hold_cnt_q, hold_cnt_d;
   logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CH_W-1:0]       win_ch_q, win_ch_d;
   logic [NUM_CH-1:0]     win_oh_q, win_oh_d;
   logic [L_W-1:0]        calc_l_mv_q, calc_l_mv_d;
   logic [N_W-1:0]        res_n_q, res_n_d;
   logic [CH_W-1:0]       res_ch_q, res_ch_d;
   logic                  res_err_q, res_err_d;
   logic                  res_valid_q, res_valid_d;
   logic [NUM_CH-1:0]     ack_q, ack_d;
   logic                  calc_en_q;

   logic [NUM_CH-1:0]     gnt_oh;
   logic [CH_W-1:0]       gnt_idx;
   logic                  gnt_any;
   logic [L_W-1:0]        gnt_sample;

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .req_i   (bus_io.req),
      .ptr_i   (rr_ptr_q),
      .grant_o (gnt_oh),
      .idx_o   (gnt_idx),
      .any_o   (gnt_any)
   );

   // Mux the winner's 12-bit sample out of the flat bus using the one-hot grant.
   always_comb begin
      gnt_sample = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (gnt_oh[c]) begin
            gnt_sample = bus_io.l_mv_flat[c*L_W +: L_W];
         end
      end
   end

   // Next-state and result logic; strobes default low so they pulse for one cycle.
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      rr_ptr_d    = rr_ptr_q;
      win_ch_d    = win_ch_q;
      win_oh_d    = win_oh_q;
      calc_l_mv_d = calc_l_mv_q;
      res_n_d     = res_n_q;
      res_ch_d    = res_ch_q;
      res_err_d   = res_err_q;
      res_valid_d = 1'b0;
      ack_d       = '0;
      unique case (state_q)
         StIdle: begin
            if (gnt_any) begin
               win_ch_d = gnt_idx;
               win_oh_d = gnt_oh;
               if (gnt_sample != '0) begin
                  calc_l_mv_d = gnt_sample;
                  hold_cnt_d  = '0;
                  state_d     = StHold;
               end else begin
                  // 0 mV has no defined order; skip the calculator entirely.
                  state_d = StErr;
               end
            end
         end
         StHold: begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            if (hold_cnt_q == CntW'(HOLD_CYCLES - 1)) begin
               state_d = StCapture;
            end
         end
         StCapture: begin
            // calc_n changes on negedge, so it is stable half a cycle before this edge.
            res_n_d     = bus_io.calc_n;
            res_err_d   = 1'b0;
            res_valid_d = 1'b1;
            res_ch_d    = win_ch_q;
            ack_d       = win_oh_q;
            rr_ptr_d    = ch_wrap_inc(win_ch_q, NUM_CH);
            state_d     = StIdle;
         end
         StErr: begin
            res_n_d     = N_ERR;
            res_err_d   = 1'b1;
            res_valid_d = 1'b1;
            res_ch_d    = win_ch_q;
            ack_d       = win_oh_q;
            rr_ptr_d    = ch_wrap_inc(win_ch_q, NUM_CH);
            state_d     = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers; calc_en rises on the first edge after reset and stays high.
   always_ff @(posedge clk_50 or posedge areset) begin
      if (areset) begin
         state_q     <= StIdle;
         hold_cnt_q  <= '0;
         rr_ptr_q    <= '0;
         win_ch_q    <= '0;
         win_oh_q    <= '0;
         calc_l_mv_q <= '0;
         res_n_q     <= '0;
         res_ch_q    <= '0;
         res_err_q   <= 1'b0;
         res_valid_q <= 1'b0;
         ack_q       <= '0;
         calc_en_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         win_ch_q    <= win_ch_d;
         win_oh_q    <= win_oh_d;
         calc_l_mv_q <= calc_l_mv_d;
         res_n_q     <= res_n_d;
         res_ch_q    <= res_ch_d;
         res_err_q   <= res_err_d;
         res_valid_q <= res_valid_d;
         ack_q       <= ack_d;
         calc_en_q   <= 1'b1;
      end
   end

   assign bus_io.ack       = ack_q;
   assign bus_io.busy      = (state_q == StHold) || (state_q == StCapture);
   assign bus_io.res_valid = res_valid_q;
   assign bus_io.res_ch    = res_ch_q;
   assign bus_io.res_n     = res_n_q;
   assign bus_io.res_err   = res_err_q;
   assign bus_io.calc_en   = calc_en_q;
   assign bus_io.calc_l_mv = calc_l_mv_q;

endmodule

// File: tb/tb_diff_order_scheduler.sv
// Self-checking bench for diff_order_scheduler with a free-running calculator model.
module tb_diff_order_scheduler;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned HOLD   = 42;
   localparam int          LAT    = HOLD + 2;  // ticks from req drive to res_valid
   localparam int          ELAT   = 2;         // same for the zero-sample error path
   localparam int          MAXW   = 200;

   typedef struct packed {
      logic [2:0]  ch;
      logic [15:0] n;
      logic        err;
   } exp_t;

   logic clk_50 = 1'b0;
   logic areset = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   logic [3:0] mon_ack;

   diff_order_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

   diff_order_scheduler #(
      .NUM_CH      (NUM_CH),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk_50 (clk_50),
      .areset (areset),
      .bus_io (bus)
   );

   always #10 clk_50 = ~clk_50;

   function automatic logic [15:0] calc_model(input logic [11:0] x);
      return 16'(32'(x) * 13 + 5);
   endfunction

   // Calculator model: 21-cycle frames on negedge, result reflects input seen at frame start.
   int         frame_cnt = 7;
   logic [11:0] frame_lmv = '0;
   always @(negedge clk_50) begin
      if (frame_cnt == 0) frame_lmv = bus.calc_l_mv;
      if (frame_cnt == 20) begin
         bus.calc_n <= calc_model(frame_lmv);
         frame_cnt = 0;
      end else begin
         frame_cnt++;
      end
   end

   // Scoreboard: every result strobe must match the oldest expectation.
   always @(posedge clk_50) begin
      #1;
      if (bus.res_valid === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result: got ch=%0d n=%h err=%b, required no result",
                     bus.res_ch, bus.res_n, bus.res_err);
         end else begin
            mon_e   = exp_q.pop_front();
            mon_ack = 4'(1 << mon_e.ch);
            if ({bus.res_ch, bus.res_n, bus.res_err, bus.ack} !==
                {mon_e.ch, mon_e.n, mon_e.err, mon_ack}) begin
               n_fail++;
               $display("FAIL result: got ch=%0d n=%h err=%b ack=%b, required ch=%0d n=%h err=%b ack=%b",
                        bus.res_ch, bus.res_n, bus.res_err, bus.ack,
                        mon_e.ch, mon_e.n, mon_e.err, mon_ack);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_50);
      #1;
   endtask

   task automatic set_sample(input int c, input logic [11:0] v);
      bus.l_mv_flat[c*12 +: 12] = v;
   endtask

   task automatic push_exp(input int c, input logic [11:0] v);
      exp_t e;
      e.ch  = 3'(c);
      e.n   = (v == 0) ? 16'hFFFF : calc_model(v);
      e.err = (v == 0);
      exp_q.push_back(e);
   endtask

   // Waits for the next strobe (bounded); drops the acked request lines. cyc=-1 on timeout.
   task automatic wait_result(input int max_cyc, output int cyc);
      cyc = -1;
      for (int i = 1; i <= max_cyc; i++) begin
         tick();
         if (bus.res_valid === 1'b1) begin
            bus.req = bus.req & ~bus.ack;
            cyc = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bus.req       = '0;
      bus.l_mv_flat = '0;
      areset        = 1'b1;
      repeat (3) tick();
      n_checks++;
      if ({bus.ack, bus.busy, bus.res_valid, bus.res_err, bus.calc_en, bus.res_ch, bus.res_n,
           bus.calc_l_mv} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ack=%b busy=%b rv=%b err=%b en=%b ch=%0d n=%h lmv=%0d, required all 0",
                  bus.ack, bus.busy, bus.res_valid, bus.res_err, bus.calc_en, bus.res_ch,
                  bus.res_n, bus.calc_l_mv);
      end
      @(negedge clk_50);
      areset = 1'b0;
      #1;
      n_checks++;
      if (bus.calc_en !== 1'b0) begin
         n_fail++;
         $display("FAIL calc_en_before_edge: got %b, required 0", bus.calc_en);
      end
      tick();
      n_checks++;
      if (bus.calc_en !== 1'b1) begin
         n_fail++;
         $display("FAIL calc_en_after_edge: got %b, required 1", bus.calc_en);
      end
      repeat (2) tick();
      n_checks++;
      if ({bus.busy, bus.res_valid, bus.calc_en} !== 3'b001) begin
         n_fail++;
         $display("FAIL idle_no_req: got busy=%b rv=%b en=%b, required 0 0 1",
                  bus.busy, bus.res_valid, bus.calc_en);
      end
   endtask

   task automatic test_all_channels();
      logic [11:0] s[4];
      int c;
      s[0] = 12'd500; s[1] = 12'd1000; s[2] = 12'd1500; s[3] = 12'd2000;
      for (int i = 0; i < 4; i++) begin
         set_sample(i, s[i]);
         push_exp(i, s[i]);
      end
      bus.req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         wait_result(MAXW, c);
         n_checks++;
         if (c != LAT) begin
            n_fail++;
            $display("FAIL all_spacing[%0d]: got %0d cycles, required %0d", i, c, LAT);
         end
         n_checks++;
         if (bus.res_ch !== 3'(i) || bus.calc_l_mv !== s[i]) begin
            n_fail++;
            $display("FAIL all_order[%0d]: got ch=%0d lmv=%0d, required ch=%0d lmv=%0d",
                     i, bus.res_ch, bus.calc_l_mv, i, s[i]);
         end
      end
   endtask

   task automatic test_wrap();
      int c;
      logic [2:0] order[3];
      order[0] = 3'd0; order[1] = 3'd3; order[2] = 3'd0;
      set_sample(3, 12'd2500);
      push_exp(3, 12'd2500);
      bus.req = 4'b1000;
      wait_result(MAXW, c);
      n_checks++;
      if (c != LAT) begin
         n_fail++;
         $display("FAIL wrap_first: got %0d cycles, required %0d", c, LAT);
      end
      set_sample(0, 12'd300);
      push_exp(0, 12'd300);
      push_exp(3, 12'd2500);
      push_exp(0, 12'd300);
      bus.req = 4'b1001;
      for (int i = 0; i < 3; i++) begin
         wait_result(MAXW, c);
         // Served ch0 re-requests at once; it must queue behind pending ch3.
         if (i == 0) bus.req[0] = 1'b1;
         n_checks++;
         if (c == -1 || bus.res_ch !== order[i]) begin
            n_fail++;
            $display("FAIL wrap_order[%0d]: got ch=%0d cycles=%0d, required ch=%0d",
                     i, bus.res_ch, c, order[i]);
         end
      end
   endtask

   task automatic test_single();
      int c;
      set_sample(2, 12'd1200);
      push_exp(2, 12'd1200);
      bus.req = 4'b0100;
      tick();
      n_checks++;
      if (bus.calc_l_mv !== 12'd1200 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_grant: got lmv=%0d busy=%b, required lmv=1200 busy=1",
                  bus.calc_l_mv, bus.busy);
      end
      wait_result(MAXW, c);
      n_checks++;
      if (c == -1 || c + 1 != LAT) begin
         n_fail++;
         $display("FAIL single_latency: got %0d cycles, required %0d", c + 1, LAT);
      end
      tick();
      n_checks++;
      if ({bus.res_valid, bus.ack, bus.busy} !== 6'b0 || bus.res_ch !== 3'd2) begin
         n_fail++;
         $display("FAIL single_pulse: got rv=%b ack=%b busy=%b ch=%0d, required 0 0000 0 ch=2",
                  bus.res_valid, bus.ack, bus.busy, bus.res_ch);
      end
   endtask

   task automatic test_zero_sample();
      int c;
      set_sample(1, 12'd0);
      push_exp(1, 12'd0);
      bus.req = 4'b0010;
      tick();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_err_state: got busy=%b rv=%b, required 0 0", bus.busy, bus.res_valid);
      end
      wait_result(MAXW, c);
      n_checks++;
      if (c == -1 || c + 1 != ELAT) begin
         n_fail++;
         $display("FAIL zero_latency: got %0d cycles, required %0d", c + 1, ELAT);
      end
      n_checks++;
      if (bus.calc_l_mv !== 12'd1200 || bus.res_err !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_hold_input: got lmv=%0d err=%b, required lmv=1200 err=1",
                  bus.calc_l_mv, bus.res_err);
      end
   endtask

   task automatic test_reset_mid_hold();
      int c;
      set_sample(2, 12'd3000);
      bus.req = 4'b0100;
      repeat (21) tick();  // hold_cnt is now 20
      n_checks++;
      if (bus.busy !== 1'b1 || bus.calc_l_mv !== 12'd3000) begin
         n_fail++;
         $display("FAIL midhold_busy: got busy=%b lmv=%0d, required 1 3000", bus.busy, bus.calc_l_mv);
      end
      areset = 1'b1;
      #1;
      n_checks++;
      if ({bus.ack, bus.busy, bus.res_valid, bus.res_err, bus.calc_en, bus.res_ch, bus.res_n,
           bus.calc_l_mv} !== '0) begin
         n_fail++;
         $display("FAIL midhold_reset: got ack=%b busy=%b rv=%b err=%b en=%b ch=%0d n=%h lmv=%0d, required all 0",
                  bus.ack, bus.busy, bus.res_valid, bus.res_err, bus.calc_en, bus.res_ch,
                  bus.res_n, bus.calc_l_mv);
      end
      repeat (2) tick();
      push_exp(2, 12'd3000);
      @(negedge clk_50);
      areset = 1'b0;
      wait_result(MAXW, c);
      n_checks++;
      if (c != LAT) begin
         n_fail++;
         $display("FAIL midhold_reissue: got %0d cycles, required %0d", c, LAT);
      end
   endtask

   task automatic test_drop_during_hold();
      int c;
      set_sample(0, 12'd700);
      push_exp(0, 12'd700);
      bus.req = 4'b0001;
      repeat (11) tick();  // hold_cnt is now 10
      bus.req[0] = 1'b0;
      wait_result(MAXW, c);
      n_checks++;
      if (c == -1 || c + 11 != LAT) begin
         n_fail++;
         $display("FAIL drop_latency: got %0d cycles, required %0d", c + 11, LAT);
      end
      tick();
      n_checks++;
      if ({bus.busy, bus.ack, bus.res_valid} !== 6'b0) begin
         n_fail++;
         $display("FAIL drop_after: got busy=%b ack=%b rv=%b, required 0 0000 0",
                  bus.busy, bus.ack, bus.res_valid);
      end
   endtask

   initial begin
      test_reset();
      test_all_channels();
      test_wrap();
      test_single();
      test_zero_sample();
      test_reset_mid_hold();
      test_drop_during_hold();
      repeat (5) tick();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
